// File: rtl/rv32v_reduction_sequencer_pkg.sv
// Shared types and constants for the rv32v reduction sequencer: element/op types,
// FSM state encoding, per-op identities and op support decode.
package rv32v_reduction_sequencer_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    VALU_ADD = 4'd0,
    VALU_SUB = 4'd1,
    VALU_AND = 4'd2,
    VALU_OR  = 4'd3,
    VALU_XOR = 4'd4,
    VALU_MAX = 4'd5,
    VALU_MIN = 4'd6,
    VALU_SLL = 4'd7,
    VALU_SRL = 4'd8
  } valuop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } red_state_t;

  localparam word_t RED_ID_ZERO    = 32'h0000_0000;
  localparam word_t RED_ID_ONES    = 32'hFFFF_FFFF;
  localparam word_t RED_ID_SMIN    = 32'h8000_0000;
  localparam word_t RED_ID_SMAX    = 32'h7FFF_FFFF;
  localparam word_t RED_BAD_RESULT = 32'hbad1_bad1;

  function automatic logic red_supported(input valuop_t op);
    case (op)
      VALU_ADD, VALU_AND, VALU_OR, VALU_XOR, VALU_MAX, VALU_MIN: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Value that leaves the running result unchanged when folded in.
  function automatic word_t red_identity(input valuop_t op, input logic uns);
    case (op)
      VALU_AND: return RED_ID_ONES;
      VALU_MAX: return uns ? RED_ID_ZERO : RED_ID_SMIN;
      VALU_MIN: return uns ? RED_ID_ONES : RED_ID_SMAX;
      default:  return RED_ID_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/rv32v_reduction_sequencer_if.sv
// Command, register-read and writeback signals of the reduction sequencer.
// master = execute-stage environment, slave = sequencer.
interface rv32v_reduction_sequencer_if
  import rv32v_reduction_sequencer_pkg::*;
#(
  parameter int LANES = 4,
  parameter int VL_W  = 8
);
  logic                  start;
  valuop_t               valuop;
  logic                  vopunsigned;
  logic [VL_W-1:0]       vl;
  logic                  vmask_en;
  word_t                 scalar_in;
  logic                  busy;
  logic                  rd_req;
  logic [VL_W-3:0]       rd_beat;
  logic                  rd_valid;
  word_t [LANES-1:0]     rd_data;
  logic [LANES-1:0]      rd_mask;
  logic                  res_valid;
  logic                  res_ready;
  word_t                 res_data;
  logic                  res_wen;

  modport master (
    output start, valuop, vopunsigned, vl, vmask_en, scalar_in,
    output rd_valid, rd_data, rd_mask, res_ready,
    input  busy, rd_req, rd_beat, res_valid, res_data, res_wen
  );

  modport slave (
    input  start, valuop, vopunsigned, vl, vmask_en, scalar_in,
    input  rd_valid, rd_data, rd_mask, res_ready,
    output busy, rd_req, rd_beat, res_valid, res_data, res_wen
  );
endinterface

// File: rtl/rv32v_red_combine.sv
// Combinational two-operand reduction step: y = op(a, b), with signed or
// unsigned ordering for max/min.
module rv32v_red_combine
  import rv32v_reduction_sequencer_pkg::*;
(
  input  valuop_t op,
  input  logic    uns,
  input  word_t   a,
  input  word_t   b,
  output word_t   y
);
  logic a_lt_b;

  always_comb begin
    a_lt_b = uns ? (a < b) : ($signed(a) < $signed(b));
    case (op)
      VALU_ADD: y = a + b;
      VALU_AND: y = a & b;
      VALU_OR:  y = a | b;
      VALU_XOR: y = a ^ b;
      VALU_MAX: y = a_lt_b ? b : a;
      VALU_MIN: y = a_lt_b ? a : b;
      default:  y = a;
    endcase
  end
endmodule

// File: rtl/rv32v_reduction_sequencer.sv
// Multi-beat vector reduction front end: reads 4-lane beats, masks/tails them,
// folds into an accumulator, returns the scalar. Macro RV32V_RED_BACK_TO_BACK_EN
// removes the bubble between beats.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | rd_req high for current beat
// WAIT  | one-cycle bubble between beats
// DONE  | result held until res_ready
module rv32v_reduction_sequencer
  import rv32v_reduction_sequencer_pkg::*;
#(
  parameter int LANES = 4,
  parameter int VL_W  = 8
)
(
  input logic CLK,
  input logic RST,
  rv32v_reduction_sequencer_if.slave bus
);
  red_state_t      state_q, state_d;
  valuop_t         op_q;
  logic            uns_q, men_q;
  logic [VL_W-1:0] vl_q;
  logic [VL_W-3:0] beat_q;
  word_t           acc_q, res_data_q;
  logic            res_wen_q;

  logic            load_cmd, accept, last_beat;
  logic [VL_W-1:0] last_idx;
  word_t           ident, pair01, pair23, beat_fold, acc_next;
  word_t           lane_v [LANES];

  assign ident     = red_identity(op_q, uns_q);
  assign last_idx  = (vl_q - VL_W'(1)) >> 2;
  assign last_beat = (last_idx == {2'b00, beat_q});
  assign accept    = (state_q == REQ) && bus.rd_valid;

  // Lanes that are masked off or past vl contribute the op identity.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_v[i] = ident;
      if ((!men_q || bus.rd_mask[i]) && ({beat_q, 2'(i)} < vl_q))
        lane_v[i] = bus.rd_data[i];
    end
  end

  rv32v_red_combine u_pair01 (.op(op_q), .uns(uns_q), .a(lane_v[0]), .b(lane_v[1]), .y(pair01));
  rv32v_red_combine u_pair23 (.op(op_q), .uns(uns_q), .a(lane_v[2]), .b(lane_v[3]), .y(pair23));
  rv32v_red_combine u_beat   (.op(op_q), .uns(uns_q), .a(pair01),    .b(pair23),    .y(beat_fold));
  rv32v_red_combine u_acc    (.op(op_q), .uns(uns_q), .a(acc_q),     .b(beat_fold), .y(acc_next));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_cmd = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load_cmd = 1'b1;
          if (bus.vl == '0 || !red_supported(bus.valuop)) state_d = DONE;
          else                                            state_d = REQ;
        end
      end
      REQ: begin
        if (accept) begin
          if (last_beat) state_d = DONE;
          else begin
`ifdef RV32V_RED_BACK_TO_BACK_EN
            state_d = REQ;
`else
            state_d = WAIT;
`endif
          end
        end
      end
      WAIT:    state_d = REQ;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q       <= VALU_ADD;
      uns_q      <= 1'b0;
      men_q      <= 1'b0;
      vl_q       <= '0;
      beat_q     <= '0;
      acc_q      <= '0;
      res_data_q <= '0;
      res_wen_q  <= 1'b0;
    end else begin
      if (load_cmd) begin
        op_q   <= bus.valuop;
        uns_q  <= bus.vopunsigned;
        men_q  <= bus.vmask_en;
        vl_q   <= bus.vl;
        acc_q  <= bus.scalar_in;
        beat_q <= '0;
        if (!red_supported(bus.valuop)) begin
          res_data_q <= RED_BAD_RESULT;
          res_wen_q  <= 1'b0;
        end else if (bus.vl == '0) begin
          res_data_q <= bus.scalar_in;
          res_wen_q  <= 1'b0;
        end
      end
      if (accept) begin
        acc_q  <= acc_next;
        beat_q <= beat_q + (VL_W-2)'(1);
        if (last_beat) begin
          res_data_q <= acc_next;
          res_wen_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.rd_req    = (state_q == REQ);
  assign bus.rd_beat   = beat_q;
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_data_q;
  assign bus.res_wen   = res_wen_q;
endmodule

// File: tb/tb_rv32v_reduction_sequencer.sv
// Directed self-checking bench for rv32v_reduction_sequencer with a result
// scoreboard; expected latencies follow RV32V_RED_BACK_TO_BACK_EN when defined.
module tb_rv32v_reduction_sequencer;
  import rv32v_reduction_sequencer_pkg::*;

  typedef struct {
    word_t data;
    logic  wen;
  } exp_t;

  logic  clk;
  logic  rst;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    stall_left = 0;
  exp_t  sb[$];
  word_t mem_d [64][4];
  logic [3:0] mem_m [64];

  rv32v_reduction_sequencer_if #(.LANES(4), .VL_W(8)) bus ();

  rv32v_reduction_sequencer #(.LANES(4), .VL_W(8)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int n);
`ifdef RV32V_RED_BACK_TO_BACK_EN
    return n + 1;
`else
    return 2 * n;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input int b, input word_t d0, input word_t d1,
                          input word_t d2, input word_t d3, input logic [3:0] m);
    mem_d[b][0] = d0;
    mem_d[b][1] = d1;
    mem_d[b][2] = d2;
    mem_d[b][3] = d3;
    mem_m[b]    = m;
  endtask

  // Read port model: beat data by index, optional rd_valid stall while rd_req.
  initial begin
    bus.rd_valid = 1'b1;
    bus.rd_data  = '0;
    bus.rd_mask  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) bus.rd_data[i] = mem_d[int'(bus.rd_beat)][i];
      bus.rd_mask = mem_m[int'(bus.rd_beat)];
      if (bus.rd_req && stall_left > 0) begin
        bus.rd_valid = 1'b0;
        stall_left--;
      end else begin
        bus.rd_valid = 1'b1;
      end
    end
  end

  task automatic start_cmd(input valuop_t op, input logic uns, input logic [7:0] vl,
                           input logic men, input word_t s, input word_t ed, input logic ew);
    exp_t e;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.valuop      = op;
    bus.vopunsigned = uns;
    bus.vl          = vl;
    bus.vmask_en    = men;
    bus.scalar_in   = s;
    e.data = ed;
    e.wen  = ew;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Entered at the falling edge of cycle 1 after the start edge.
  task automatic wait_result(input string tag, input int lat, input logic exp_reads, input int hold);
    int    k;
    logic  saw;
    exp_t  e;
    word_t held;
    k   = 1;
    saw = bus.rd_req;
    while (!bus.res_valid && k < 300) begin
      @(negedge clk);
      k++;
      saw = saw | bus.rd_req;
    end
    check({tag, "_valid"}, bus.res_valid, 1);
    check({tag, "_lat"}, k, lat);
    check({tag, "_reads"}, saw, exp_reads);
    check({tag, "_sb_len"}, sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, bus.res_data, e.data);
      check({tag, "_wen"}, bus.res_wen, e.wen);
    end
    if (hold > 0) begin
      held = bus.res_data;
      for (int c = 0; c < hold; c++) begin
        bus.start     = (c == 1);
        bus.valuop    = VALU_ADD;
        bus.vl        = 8'd4;
        bus.scalar_in = 32'h5555;
        @(negedge clk);
        check({tag, "_hold_valid"}, bus.res_valid, 1);
        check({tag, "_hold_data"}, bus.res_data, held);
      end
      // start coincident with the handshake must also be dropped
      bus.start = 1'b1;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy_after"}, bus.busy, 0);
    check({tag, "_valid_after"}, bus.res_valid, 0);
  endtask

  task automatic run_op(input string tag, input valuop_t op, input logic uns, input logic [7:0] vl,
                        input logic men, input word_t s, input word_t ed, input logic ew,
                        input int lat, input logic exp_reads, input int hold);
    start_cmd(op, uns, vl, men, s, ed, ew);
    wait_result(tag, lat, exp_reads, hold);
  endtask

  initial begin
    int k;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.valuop      = VALU_ADD;
    bus.vopunsigned = 1'b0;
    bus.vl          = '0;
    bus.vmask_en    = 1'b0;
    bus.scalar_in   = '0;
    bus.res_ready   = 1'b1;
    for (int b = 0; b < 64; b++) set_beat(b, 0, 0, 0, 0, 4'b0000);
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_rd_req", bus.rd_req, 0);
    check("rst_rd_beat", bus.rd_beat, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_wen", bus.res_wen, 0);
    rst = 1'b0;

    set_beat(0, 1, 2, 3, 4, 4'b1111);
    set_beat(1, 5, 6, 99, 99, 4'b1111);
    run_op("add_vl6", VALU_ADD, 0, 8'd6, 0, 32'd10, 32'd31, 1, lat_of(2), 1, 0);

    set_beat(0, 32'hFFFF_FFFD, 0, 1, 2, 4'b0000);
    run_op("min_masked", VALU_MIN, 0, 8'd4, 1, 32'd5, 32'd5, 1, lat_of(1), 1, 0);

    set_beat(0, 3, 32'hFFFF_FFFF, 7, 1, 4'b1111);
    set_beat(1, 2, 32'h8000_0000, 5, 0, 4'b1111);
    run_op("maxu", VALU_MAX, 1, 8'd8, 0, 32'd0, 32'hFFFF_FFFF, 1, lat_of(2), 1, 0);
    run_op("max_signed", VALU_MAX, 0, 8'd8, 0, 32'd0, 32'd7, 1, lat_of(2), 1, 0);

    set_beat(0, 5, 9, 2, 0, 4'b1111);
    run_op("minu_tail", VALU_MIN, 1, 8'd3, 0, 32'd100, 32'd2, 1, lat_of(1), 1, 0);

    set_beat(0, 32'hFF, 32'hF0F, 32'hFFF, 32'hFFFF, 4'b1111);
    run_op("and_vl4", VALU_AND, 0, 8'd4, 0, 32'hFFFF_FFFF, 32'h0F, 1, lat_of(1), 1, 0);

    run_op("vl_zero", VALU_ADD, 0, 8'd0, 0, 32'h1234, 32'h1234, 0, 1, 0, 0);
    run_op("unsupported", VALU_SUB, 0, 8'd4, 0, 32'h77, 32'hbad1_bad1, 0, 1, 0, 0);

    set_beat(0, 1, 2, 4, 8, 4'b1011);
    set_beat(1, 16, 32, 64, 128, 4'b1111);
    bus.res_ready = 1'b0;
    run_op("or_hold", VALU_OR, 0, 8'd5, 1, 32'h100, 32'h11B, 1, lat_of(2), 1, 5);

    set_beat(0, 1, 2, 4, 8, 4'b0000);
    set_beat(1, 16, 32, 64, 128, 4'b0000);
    stall_left = 3;
    run_op("xor_stall", VALU_XOR, 0, 8'd8, 0, 32'd0, 32'hFF, 1, lat_of(2) + 3, 1, 0);

    // abort mid-operation with reset
    set_beat(0, 1, 2, 3, 4, 4'b1111);
    set_beat(1, 5, 6, 7, 8, 4'b1111);
    start_cmd(VALU_ADD, 0, 8'd8, 0, 32'd1, 32'd37, 1);
    k = 0;
    while (!(bus.rd_req && bus.rd_beat == 6'd1) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("abort_reach_beat1", bus.rd_beat, 1);
    check("abort_reach_req", bus.rd_req, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_rd_req", bus.rd_req, 0);
    check("abort_rd_beat", bus.rd_beat, 0);
    check("abort_res_valid", bus.res_valid, 0);
    check("abort_res_data", bus.res_data, 0);
    check("abort_res_wen", bus.res_wen, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    check("abort_res_valid_held", bus.res_valid, 0);
    rst = 1'b0;

    set_beat(0, 1, 1, 1, 1, 4'b1111);
    run_op("add_after_rst", VALU_ADD, 0, 8'd4, 0, 32'd0, 32'd4, 1, lat_of(1), 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
